// File: rtl/alarm_pkg.sv
// alarm_pkg: shared encodings and field widths for the alarm bank.
//   state_t      per-channel FSM state (idle / ringing / snoozed)
//   SUN..SAT     day-of-week codes, 0 = Sunday
//   HOUR_W/MIN_W/DAY_W  time field widths
//   day_hit()    day-mask test; an empty mask means "any day"
package alarm_pkg;

   localparam int HOUR_W = 5;
   localparam int MIN_W  = 6;
   localparam int DAY_W  = 3;
   localparam int CNT_W  = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RING = 2'd1,
      ST_SNZ  = 2'd2
   } state_t;

   localparam logic [DAY_W-1:0] SUN = 3'd0;
   localparam logic [DAY_W-1:0] MON = 3'd1;
   localparam logic [DAY_W-1:0] TUE = 3'd2;
   localparam logic [DAY_W-1:0] WED = 3'd3;
   localparam logic [DAY_W-1:0] THU = 3'd4;
   localparam logic [DAY_W-1:0] FRI = 3'd5;
   localparam logic [DAY_W-1:0] SAT = 3'd6;

   // Day code 7 is not a real day and never hits a non-empty mask.
   function automatic logic day_hit(input logic [6:0] days, input logic [DAY_W-1:0] day);
      if (days == 7'd0)
         return 1'b1;
      else if (day > SAT)
         return 1'b0;
      else
         return days[day];
   endfunction

endpackage

// File: rtl/alarm_channel.sv
// alarm_channel: one alarm channel - programmed time/day mask, match logic,
// ring/snooze FSM with ring and snooze minute counters.
// Build option: ALARM_SNOOZE_LIMIT_EN adds a 2-bit snooze counter; the fourth
// Snooze in one ring episode behaves like Stop.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   min_tick, cur_*     minute strobe and current time (sampled on min_tick)
//   wr_sel, wr_*        load strobe (already decoded) and programmed values
//   snooze, stop        1-cycle control pulses shared by all channels
//   ringing, snoozed    FSM state flags
//   armed               channel enable
//
//   state   | meaning
//   ST_IDLE | waiting for a match
//   ST_RING | buzzing, ring_cnt counts unattended minutes
//   ST_SNZ  | silenced, snz_cnt counts down to re-ring
import alarm_pkg::*;

module alarm_channel #(
   parameter int SNOOZE_MIN = 9,
   parameter int RING_MAX   = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              min_tick,
   input  logic [HOUR_W-1:0] cur_hour,
   input  logic [MIN_W-1:0]  cur_min,
   input  logic [DAY_W-1:0]  cur_day,
   input  logic              wr_sel,
   input  logic [HOUR_W-1:0] wr_hour,
   input  logic [MIN_W-1:0]  wr_min,
   input  logic [6:0]        wr_days,
   input  logic              wr_arm,
   input  logic              snooze,
   input  logic              stop,
   output logic              ringing,
   output logic              snoozed,
   output logic              armed
);

   state_t              state, state_nx;
   logic [HOUR_W-1:0]   hour, hour_nx;
   logic [MIN_W-1:0]    minute, minute_nx;
   logic [6:0]          days, days_nx;
   logic                arm, arm_nx;
   logic [CNT_W-1:0]    ring_cnt, ring_nx;
   logic [CNT_W-1:0]    snz_cnt, snz_nx;
   logic [CNT_W-1:0]    ring_inc, snz_dec;
   logic                hit, go_idle;
`ifdef ALARM_SNOOZE_LIMIT_EN
   logic [1:0]          lim, lim_nx;
`endif

   assign hit = min_tick & arm & (hour == cur_hour) & (minute == cur_min)
              & day_hit(days, cur_day);

   assign ring_inc = (ring_cnt == '1) ? ring_cnt : ring_cnt + 1'b1;
   assign snz_dec  = (snz_cnt == '0) ? snz_cnt : snz_cnt - 1'b1;

   // Stop/Snooze only take precedence when they actually apply to the
   // current state; otherwise a concurrent write or tick still goes through.
   always_comb begin
      state_nx  = state;
      hour_nx   = hour;
      minute_nx = minute;
      days_nx   = days;
      arm_nx    = arm;
      ring_nx   = ring_cnt;
      snz_nx    = snz_cnt;
      go_idle   = 1'b0;
`ifdef ALARM_SNOOZE_LIMIT_EN
      lim_nx    = lim;
`endif
      if (stop && state != ST_IDLE) begin
         go_idle = 1'b1;
      end else if (snooze && state == ST_RING) begin
`ifdef ALARM_SNOOZE_LIMIT_EN
         if (lim == 2'd3) begin
            go_idle = 1'b1;
         end else begin
            state_nx = ST_SNZ;
            snz_nx   = CNT_W'(SNOOZE_MIN);
            lim_nx   = lim + 2'd1;
         end
`else
         state_nx = ST_SNZ;
         snz_nx   = CNT_W'(SNOOZE_MIN);
`endif
      end else if (wr_sel) begin
         hour_nx   = wr_hour;
         minute_nx = wr_min;
         days_nx   = wr_days;
         arm_nx    = wr_arm;
         go_idle   = 1'b1;
      end else if (min_tick) begin
         unique case (state)
            ST_IDLE: begin
               if (hit) begin
                  state_nx = ST_RING;
                  ring_nx  = '0;
                  if (days == 7'd0)
                     arm_nx = 1'b0;
               end
            end
            ST_RING: begin
               if (ring_inc >= CNT_W'(RING_MAX))
                  go_idle = 1'b1;
               else
                  ring_nx = ring_inc;
            end
            ST_SNZ: begin
               if (snz_dec == '0) begin
                  state_nx = ST_RING;
                  ring_nx  = '0;
                  snz_nx   = '0;
               end else begin
                  snz_nx = snz_dec;
               end
            end
            default: go_idle = 1'b1;
         endcase
      end
      if (go_idle) begin
         state_nx = ST_IDLE;
         ring_nx  = '0;
         snz_nx   = '0;
`ifdef ALARM_SNOOZE_LIMIT_EN
         lim_nx   = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         hour     <= '0;
         minute   <= '0;
         days     <= '0;
         arm      <= 1'b0;
         ring_cnt <= '0;
         snz_cnt  <= '0;
`ifdef ALARM_SNOOZE_LIMIT_EN
         lim      <= '0;
`endif
      end else begin
         state    <= state_nx;
         hour     <= hour_nx;
         minute   <= minute_nx;
         days     <= days_nx;
         arm      <= arm_nx;
         ring_cnt <= ring_nx;
         snz_cnt  <= snz_nx;
`ifdef ALARM_SNOOZE_LIMIT_EN
         lim      <= lim_nx;
`endif
      end
   end

   assign ringing = (state == ST_RING);
   assign snoozed = (state == ST_SNZ);
   assign armed   = arm;

endmodule

// File: rtl/alarm_bank.sv
// alarm_bank: N_ALARMS independent alarm channels sharing one buzzer.
// Build option: ALARM_SNOOZE_LIMIT_EN (see alarm_channel) caps snoozes per ring.
// Ports:
//   Clk, Reset            clock, async active-low reset
//   min_tick, cur_*       minute strobe and current hour/minute/day
//   wr_en, wr_ch, wr_*    program one channel (forces it idle)
//   Snooze, Stop          pulses applied to every channel
//   Mute                  level, silences Sound only
//   Sound                 registered buzzer enable
//   ringing, snoozed      per-channel state flags
//   active_ch             lowest-index ringing channel, 0 when none
//   armed                 per-channel enable bits
import alarm_pkg::*;

module alarm_bank #(
   parameter int N_ALARMS   = 4,
   parameter int SNOOZE_MIN = 9,
   parameter int RING_MAX   = 10,
   parameter int CW         = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                min_tick,
   input  logic [HOUR_W-1:0]   cur_hour,
   input  logic [MIN_W-1:0]    cur_min,
   input  logic [DAY_W-1:0]    cur_day,
   input  logic                wr_en,
   input  logic [CW-1:0]       wr_ch,
   input  logic [HOUR_W-1:0]   wr_hour,
   input  logic [MIN_W-1:0]    wr_min,
   input  logic [6:0]          wr_days,
   input  logic                wr_arm,
   input  logic                Snooze,
   input  logic                Stop,
   input  logic                Mute,
   output logic                Sound,
   output logic [N_ALARMS-1:0] ringing,
   output logic [N_ALARMS-1:0] snoozed,
   output logic [CW-1:0]       active_ch,
   output logic [N_ALARMS-1:0] armed
);

   // An out-of-range wr_ch simply matches no channel.
   for (genvar i = 0; i < N_ALARMS; i++) begin : g_ch
      logic wr_sel;
      assign wr_sel = wr_en && (wr_ch == CW'(i));

      alarm_channel #(
         .SNOOZE_MIN (SNOOZE_MIN),
         .RING_MAX   (RING_MAX)
      ) u_ch (
         .clk      (Clk),
         .rst_n    (Reset),
         .min_tick (min_tick),
         .cur_hour (cur_hour),
         .cur_min  (cur_min),
         .cur_day  (cur_day),
         .wr_sel   (wr_sel),
         .wr_hour  (wr_hour),
         .wr_min   (wr_min),
         .wr_days  (wr_days),
         .wr_arm   (wr_arm),
         .snooze   (Snooze),
         .stop     (Stop),
         .ringing  (ringing[i]),
         .snoozed  (snoozed[i]),
         .armed    (armed[i])
      );
   end

   always_comb begin
      active_ch = '0;
      for (int i = N_ALARMS - 1; i >= 0; i--) begin
         if (ringing[i])
            active_ch = CW'(i);
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset)
         Sound <= 1'b0;
      else
         Sound <= (|ringing) & ~Mute;
   end

endmodule

// File: tb/tb_alarm_bank.sv
module tb_alarm_bank;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic       min_tick = 1'b0;
   logic [4:0] cur_hour = '0;
   logic [5:0] cur_min = '0;
   logic [2:0] cur_day = '0;
   logic       wr_en = 1'b0;
   logic [1:0] wr_ch = '0;
   logic [4:0] wr_hour = '0;
   logic [5:0] wr_min = '0;
   logic [6:0] wr_days = '0;
   logic       wr_arm = 1'b0;
   logic       Snooze = 1'b0;
   logic       Stop = 1'b0;
   logic       Mute = 1'b0;
   logic       Sound;
   logic [3:0] ringing;
   logic [3:0] snoozed;
   logic [1:0] active_ch;
   logic [3:0] armed;

   int n_cmp = 0;
   int n_err = 0;

   always #5 Clk = ~Clk;

   alarm_bank dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .min_tick  (min_tick),
      .cur_hour  (cur_hour),
      .cur_min   (cur_min),
      .cur_day   (cur_day),
      .wr_en     (wr_en),
      .wr_ch     (wr_ch),
      .wr_hour   (wr_hour),
      .wr_min    (wr_min),
      .wr_days   (wr_days),
      .wr_arm    (wr_arm),
      .Snooze    (Snooze),
      .Stop      (Stop),
      .Mute      (Mute),
      .Sound     (Sound),
      .ringing   (ringing),
      .snoozed   (snoozed),
      .active_ch (active_ch),
      .armed     (armed)
   );

   // Stimulus helpers: drive on the falling edge, return on the next falling
   // edge so the rising edge in between has already been applied.
   task automatic tick(input logic [4:0] h, input logic [5:0] m, input logic [2:0] d);
      @(negedge Clk);
      min_tick = 1'b1; cur_hour = h; cur_min = m; cur_day = d;
      @(negedge Clk);
      min_tick = 1'b0;
   endtask

   task automatic program_ch(input logic [1:0] ch, input logic [4:0] h, input logic [5:0] m,
                             input logic [6:0] days, input logic arm);
      @(negedge Clk);
      wr_en = 1'b1; wr_ch = ch; wr_hour = h; wr_min = m; wr_days = days; wr_arm = arm;
      @(negedge Clk);
      wr_en = 1'b0;
   endtask

   task automatic pulse(input logic snz, input logic stp);
      @(negedge Clk);
      Snooze = snz; Stop = stp;
      @(negedge Clk);
      Snooze = 1'b0; Stop = 1'b0;
   endtask

   task automatic test_reset;
      #2;
      n_cmp++;
      if ({Sound, ringing, snoozed, active_ch, armed} !== 15'd0) begin
         $display("FAIL reset_outputs got %b expected 0", {Sound, ringing, snoozed, active_ch, armed});
         n_err++;
      end
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
   endtask

   task automatic test_weekly;
      program_ch(2'd0, 5'd7, 6'd30, 7'b0000010, 1'b1);
      n_cmp++;
      if (armed !== 4'b0001) begin $display("FAIL weekly_armed got %b expected 0001", armed); n_err++; end
      tick(5'd7, 6'd30, 3'd1);
      n_cmp++;
      if (ringing !== 4'b0001) begin $display("FAIL weekly_ring got %b expected 0001", ringing); n_err++; end
      n_cmp++;
      if (Sound !== 1'b0) begin $display("FAIL sound_latency got %b expected 0", Sound); n_err++; end
      @(negedge Clk);
      n_cmp++;
      if (Sound !== 1'b1) begin $display("FAIL sound_on got %b expected 1", Sound); n_err++; end
      pulse(1'b0, 1'b1);
      n_cmp++;
      if (ringing !== 4'b0000) begin $display("FAIL stop_ring got %b expected 0000", ringing); n_err++; end
      n_cmp++;
      if (armed !== 4'b0001) begin $display("FAIL weekly_stays_armed got %b expected 0001", armed); n_err++; end
   endtask

   task automatic test_day_mask;
      tick(5'd7, 6'd30, 3'd2);
      n_cmp++;
      if (ringing !== 4'b0000) begin $display("FAIL wrong_day got %b expected 0000", ringing); n_err++; end
      tick(5'd7, 6'd31, 3'd1);
      n_cmp++;
      if (ringing !== 4'b0000) begin $display("FAIL wrong_minute got %b expected 0000", ringing); n_err++; end
      program_ch(2'd1, 5'd8, 6'd0, 7'b0000000, 1'b1);
      n_cmp++;
      if (armed !== 4'b0011) begin $display("FAIL oneshot_armed got %b expected 0011", armed); n_err++; end
      tick(5'd8, 6'd0, 3'd2);
      n_cmp++;
      if (ringing !== 4'b0010) begin $display("FAIL oneshot_ring got %b expected 0010", ringing); n_err++; end
      n_cmp++;
      if (armed !== 4'b0001) begin $display("FAIL oneshot_disarm got %b expected 0001", armed); n_err++; end
      pulse(1'b0, 1'b1);
      tick(5'd8, 6'd0, 3'd3);
      n_cmp++;
      if (ringing !== 4'b0000) begin $display("FAIL oneshot_repeat got %b expected 0000", ringing); n_err++; end
   endtask

   task automatic test_snooze;
      tick(5'd7, 6'd30, 3'd1);
      pulse(1'b1, 1'b0);
      n_cmp++;
      if ({ringing, snoozed} !== 8'b0000_0001) begin
         $display("FAIL snooze_enter got %b expected 00000001", {ringing, snoozed}); n_err++;
      end
      for (int i = 0; i < 8; i++) tick(5'd12, 6'd0, 3'd1);
      n_cmp++;
      if ({ringing, snoozed} !== 8'b0000_0001) begin
         $display("FAIL snooze_hold8 got %b expected 00000001", {ringing, snoozed}); n_err++;
      end
      tick(5'd12, 6'd0, 3'd1);
      n_cmp++;
      if ({ringing, snoozed} !== 8'b0001_0000) begin
         $display("FAIL snooze_rering got %b expected 00010000", {ringing, snoozed}); n_err++;
      end
      // Two more full snooze cycles, then a fourth Snooze in the same episode.
      for (int k = 0; k < 2; k++) begin
         pulse(1'b1, 1'b0);
         for (int i = 0; i < 9; i++) tick(5'd12, 6'd0, 3'd1);
      end
      n_cmp++;
      if (ringing !== 4'b0001) begin $display("FAIL snooze_third_rering got %b expected 0001", ringing); n_err++; end
      pulse(1'b1, 1'b0);
`ifdef ALARM_SNOOZE_LIMIT_EN
      n_cmp++;
      if ({ringing, snoozed} !== 8'b0000_0000) begin
         $display("FAIL snooze_limit got %b expected 00000000", {ringing, snoozed}); n_err++;
      end
`else
      n_cmp++;
      if ({ringing, snoozed} !== 8'b0000_0001) begin
         $display("FAIL snooze_unlimited got %b expected 00000001", {ringing, snoozed}); n_err++;
      end
`endif
      pulse(1'b0, 1'b1);
      n_cmp++;
      if ({ringing, snoozed} !== 8'b0000_0000) begin
         $display("FAIL snooze_stop got %b expected 00000000", {ringing, snoozed}); n_err++;
      end
   endtask

   task automatic test_timeout_mute;
      tick(5'd7, 6'd30, 3'd1);
      for (int i = 0; i < 9; i++) tick(5'd12, 6'd0, 3'd1);
      n_cmp++;
      if (ringing !== 4'b0001) begin $display("FAIL ring_9ticks got %b expected 0001", ringing); n_err++; end
      tick(5'd12, 6'd0, 3'd1);
      n_cmp++;
      if (ringing !== 4'b0000) begin $display("FAIL ring_timeout got %b expected 0000", ringing); n_err++; end
      tick(5'd7, 6'd30, 3'd1);
      pulse(1'b1, 1'b1);
      n_cmp++;
      if ({ringing, snoozed} !== 8'b0000_0000) begin
         $display("FAIL stop_beats_snooze got %b expected 00000000", {ringing, snoozed}); n_err++;
      end
      tick(5'd7, 6'd30, 3'd1);
      @(negedge Clk);
      n_cmp++;
      if (Sound !== 1'b1) begin $display("FAIL sound_unmuted got %b expected 1", Sound); n_err++; end
      Mute = 1'b1;
      @(negedge Clk);
      n_cmp++;
      if (Sound !== 1'b0) begin $display("FAIL sound_muted got %b expected 0", Sound); n_err++; end
      n_cmp++;
      if (ringing !== 4'b0001) begin $display("FAIL mute_keeps_ring got %b expected 0001", ringing); n_err++; end
      Mute = 1'b0;
      pulse(1'b0, 1'b1);
   endtask

   task automatic test_multi;
      program_ch(2'd2, 5'd6, 6'd15, 7'b0000000, 1'b1);
      program_ch(2'd3, 5'd6, 6'd15, 7'b0001000, 1'b1);
      tick(5'd6, 6'd15, 3'd3);
      n_cmp++;
      if (ringing !== 4'b1100) begin $display("FAIL multi_ring got %b expected 1100", ringing); n_err++; end
      n_cmp++;
      if (active_ch !== 2'd2) begin $display("FAIL multi_active got %0d expected 2", active_ch); n_err++; end
      n_cmp++;
      if (armed !== 4'b1001) begin $display("FAIL multi_armed got %b expected 1001", armed); n_err++; end
      program_ch(2'd2, 5'd23, 6'd59, 7'b0000000, 1'b0);
      n_cmp++;
      if (ringing !== 4'b1000) begin $display("FAIL reprogram_ring got %b expected 1000", ringing); n_err++; end
      n_cmp++;
      if (active_ch !== 2'd3) begin $display("FAIL reprogram_active got %0d expected 3", active_ch); n_err++; end
      pulse(1'b0, 1'b1);
      n_cmp++;
      if (active_ch !== 2'd0) begin $display("FAIL idle_active got %0d expected 0", active_ch); n_err++; end
   endtask

   task automatic test_async_reset;
      tick(5'd6, 6'd15, 3'd3);
      pulse(1'b1, 1'b0);
      tick(5'd7, 6'd30, 3'd1);
      @(negedge Clk);
      n_cmp++;
      if ({Sound, ringing, snoozed} !== 9'b1_0001_1000) begin
         $display("FAIL pre_reset got %b expected 100011000", {Sound, ringing, snoozed}); n_err++;
      end
      #2;
      Reset = 1'b0;
      #1;
      n_cmp++;
      if ({Sound, ringing, snoozed, active_ch, armed} !== 15'd0) begin
         $display("FAIL async_reset got %b expected 0", {Sound, ringing, snoozed, active_ch, armed});
         n_err++;
      end
   endtask

   initial begin
      test_reset();
      test_weekly();
      test_day_mask();
      test_snooze();
      test_timeout_mute();
      test_multi();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
